// File: rtl/bst_op_sched_if.sv
// Command/response bundle for the BST key-store sequencer.
// master issues commands and observes responses; slave is the controller.
interface bst_op_sched_if #(
  parameter int KEY_W = 4,
  parameter int IDX_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [KEY_W-1:0] cmd_key;
  logic             rsp_valid;
  logic             rsp_found;
  logic             rsp_err;
  logic [IDX_W-1:0] rsp_idx;
  logic [IDX_W-1:0] rsp_depth;
  logic [IDX_W-1:0] count;
  logic             empty;
  logic             full;
  logic [7:0]       led;

  modport master (
    output cmd_valid, cmd_op, cmd_key,
    input  cmd_ready, rsp_valid, rsp_found, rsp_err, rsp_idx, rsp_depth,
           count, empty, full, led
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_key,
    output cmd_ready, rsp_valid, rsp_found, rsp_err, rsp_idx, rsp_depth,
           count, empty, full, led
  );
endinterface

// File: rtl/bst_op_sched.sv
// Serialized FIND/INSERT/CLEAR sequencer for the BST node table, one node compared per clock.
// Walks answer d+2 edges after accept, CLEAR N_NODES+1; cmd_ready stays low for the whole command.
module bst_op_sched #(
  parameter int KEY_W   = 4,
  parameter int N_NODES = 7,
  parameter int IDX_W   = 3
) (
  input logic           clk,
  input logic           rst,
  bst_op_sched_if.slave io
);
  localparam logic [IDX_W-1:0] NIL       = IDX_W'(N_NODES);
  localparam logic [IDX_W-1:0] LAST      = IDX_W'(N_NODES - 1);
  localparam logic [1:0]       OP_INSERT = 2'b01;
  localparam logic [1:0]       OP_CLEAR  = 2'b10;

  typedef enum logic [2:0] {IDLE, WALK, LINK, CLR, RESP} state_t;
  state_t state, next;

  logic [KEY_W-1:0] keys [N_NODES];
  logic [IDX_W-1:0] lft  [N_NODES];
  logic [IDX_W-1:0] rgt  [N_NODES];

  logic [1:0]       op_q;
  logic [KEY_W-1:0] key_q;
  logic [IDX_W-1:0] cur, depth, parent, ptr, count_q;
  logic             left_q, has_parent;
  logic             p_found, p_err;
  logic [IDX_W-1:0] p_idx, p_depth;
  logic             rsp_valid_q, rsp_found_q, rsp_err_q;
  logic [IDX_W-1:0] rsp_idx_q, rsp_depth_q;
  logic [7:0]       led_q;

  logic             ready, accept, is_ins, empty_w, full_w;
  logic             hit, go_left, child_null, guard, can_link;
  logic [IDX_W-1:0] child, depth_inc;

  assign empty_w    = (count_q == '0);
  assign full_w     = (count_q == NIL);
  assign is_ins     = (op_q == OP_INSERT);
  assign hit        = (key_q == keys[cur]);
  assign go_left    = (key_q < keys[cur]);
  assign child      = go_left ? lft[cur] : rgt[cur];
  assign child_null = (child == NIL);
  assign depth_inc  = depth + 1'b1;
  // A legal 7-node tree never needs depth N_NODES; reaching it means corrupted links.
  assign guard      = (depth_inc == NIL);
  assign can_link   = is_ins && !full_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next   = state;
    ready  = 1'b0;
    accept = 1'b0;
    case (state)
      IDLE: begin
        ready  = 1'b1;
        accept = io.cmd_valid;
        if (io.cmd_valid) begin
          if (io.cmd_op == OP_CLEAR)  next = CLR;
          else if (empty_w)           next = (io.cmd_op == OP_INSERT) ? LINK : RESP;
          else                        next = WALK;
        end
      end
      WALK: begin
        if (hit)             next = RESP;
        else if (child_null) next = can_link ? LINK : RESP;
        else if (guard)      next = RESP;
      end
      LINK:    next = RESP;
      CLR:     if (ptr == LAST) next = RESP;
      RESP:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NODES; i++) begin
        keys[i] <= '0;
        lft[i]  <= NIL;
        rgt[i]  <= NIL;
      end
      op_q        <= '0;
      key_q       <= '0;
      cur         <= '0;
      depth       <= '0;
      parent      <= '0;
      ptr         <= '0;
      count_q     <= '0;
      left_q      <= 1'b0;
      has_parent  <= 1'b0;
      p_found     <= 1'b0;
      p_err       <= 1'b0;
      p_idx       <= NIL;
      p_depth     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_found_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_idx_q   <= NIL;
      rsp_depth_q <= '0;
      led_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_q       <= io.cmd_op;
          key_q      <= io.cmd_key;
          cur        <= '0;
          depth      <= '0;
          has_parent <= 1'b0;
          p_found    <= 1'b0;
          p_err      <= 1'b0;
          p_idx      <= NIL;
          p_depth    <= '0;
          if (io.cmd_op == OP_CLEAR) begin
            ptr     <= '0;
            count_q <= '0;
          end
        end
        WALK: begin
          if (hit) begin
            p_found <= 1'b1;
            p_idx   <= cur;
            p_depth <= depth;
          end else if (child_null) begin
            if (can_link) begin
              parent     <= cur;
              left_q     <= go_left;
              has_parent <= 1'b1;
              depth      <= depth_inc;
            end else if (is_ins) begin
              p_err <= 1'b1;
            end
          end else if (guard) begin
            p_err <= 1'b1;
          end else begin
            cur   <= child;
            depth <= depth_inc;
          end
        end
        LINK: begin
          keys[count_q] <= key_q;
          lft[count_q]  <= NIL;
          rgt[count_q]  <= NIL;
          if (has_parent) begin
            if (left_q) lft[parent] <= count_q;
            else        rgt[parent] <= count_q;
          end
          p_idx   <= count_q;
          p_depth <= depth;
          count_q <= count_q + 1'b1;
        end
        CLR: begin
          keys[ptr] <= '0;
          lft[ptr]  <= NIL;
          rgt[ptr]  <= NIL;
          ptr       <= ptr + 1'b1;
        end
        RESP: begin
          rsp_valid_q <= 1'b1;
          rsp_found_q <= p_found;
          rsp_err_q   <= p_err;
          rsp_idx_q   <= p_idx;
          rsp_depth_q <= p_depth;
          led_q       <= {p_found, count_q, key_q};
        end
        default: ;
      endcase
    end
  end

  assign io.cmd_ready = ready;
  assign io.rsp_valid = rsp_valid_q;
  assign io.rsp_found = rsp_found_q;
  assign io.rsp_err   = rsp_err_q;
  assign io.rsp_idx   = rsp_idx_q;
  assign io.rsp_depth = rsp_depth_q;
  assign io.count     = count_q;
  assign io.empty     = empty_w;
  assign io.full      = full_w;
  assign io.led       = led_q;
endmodule

// File: tb/tb_bst_op_sched.sv
// Directed bench for bst_op_sched: builds, searches, fills and clears the tree, then
// exercises held cmd_valid and reset during a walk.
module tb_bst_op_sched;
  localparam int KEY_W   = 4;
  localparam int N_NODES = 7;
  localparam int IDX_W   = 3;
  localparam logic [1:0] OP_FIND = 2'b00;
  localparam logic [1:0] OP_INS  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bst_op_sched_if #(.KEY_W(KEY_W), .IDX_W(IDX_W)) io ();

  bst_op_sched #(.KEY_W(KEY_W), .N_NODES(N_NODES), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts edges after the accept edge until rsp_valid, and post-edge samples with cmd_ready low.
  task automatic wait_rsp(output int lat, output int busy);
    lat  = 0;
    busy = 0;
    while (!io.rsp_valid && lat < 64) begin
      if (!io.cmd_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input int key, output int lat, output int busy);
    int spin;
    @(negedge clk);
    io.cmd_valid = 1'b1;
    io.cmd_op    = op;
    io.cmd_key   = KEY_W'(key);
    spin = 0;
    while (!io.cmd_ready && spin < 64) begin
      @(negedge clk);
      spin++;
    end
    @(posedge clk); #1;
    io.cmd_valid = 1'b0;
    wait_rsp(lat, busy);
  endtask

  task automatic cmd_rsp(input string tag, input logic [1:0] op, input int key, input int e_lat,
                         input int e_found, input int e_err, input int e_idx, input int e_depth);
    int lat, busy;
    do_cmd(op, key, lat, busy);
    check({tag, "_lat"},   lat,          e_lat);
    check({tag, "_found"}, io.rsp_found, e_found);
    check({tag, "_err"},   io.rsp_err,   e_err);
    check({tag, "_idx"},   io.rsp_idx,   e_idx);
    check({tag, "_depth"}, io.rsp_depth, e_depth);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "bench stopped by watchdog");
  end

  initial begin
    int ins_key [4] = '{8, 4, 12, 2};
    int ins_dep [4] = '{0, 1, 1, 2};
    int fill_key[3] = '{6, 10, 14};
    int lat, busy, pulses;

    io.cmd_valid = 1'b0;
    io.cmd_op    = OP_FIND;
    io.cmd_key   = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", io.cmd_ready, 1);
    check("rst_valid", io.rsp_valid, 0);
    check("rst_idx",   io.rsp_idx,   7);
    check("rst_count", io.count,     0);
    check("rst_empty", io.empty,     1);
    check("rst_full",  io.full,      0);
    check("rst_led",   io.led,       0);
    rst = 1'b0;

    // Build 8 / 4 12 / 2
    for (int i = 0; i < 4; i++)
      cmd_rsp($sformatf("ins%0d", i), OP_INS, ins_key[i], (i == 0) ? 2 : ins_dep[i] + 2,
              0, 0, i, ins_dep[i]);
    check("build_count", io.count,    4);
    check("build_led_c", io.led[6:4], 4);

    cmd_rsp("find2", OP_FIND, 2, 4, 1, 0, 3, 2);
    check("find2_led", io.led, 8'hC2);
    @(posedge clk); #1;
    check("pulse_width", io.rsp_valid, 0);
    check("rsp_hold",    io.rsp_idx,   3);

    cmd_rsp("find5", OP_FIND, 5, 3, 0, 0, 7, 0);
    cmd_rsp("dup4",  OP_INS,  4, 3, 1, 0, 1, 1);
    check("dup4_count", io.count, 4);
    cmd_rsp("find4", OP_FIND, 4, 3, 1, 0, 1, 1);

    for (int i = 0; i < 3; i++)
      cmd_rsp($sformatf("fill%0d", i), OP_INS, fill_key[i], 4, 0, 0, 4 + i, 2);
    check("fill_count", io.count, 7);
    check("fill_full",  io.full,  1);

    cmd_rsp("full15", OP_INS,  15, 4, 0, 1, 7, 0);
    check("full15_count", io.count, 7);
    cmd_rsp("full14", OP_INS,  14, 4, 1, 0, 6, 2);
    cmd_rsp("find10", OP_FIND, 10, 4, 1, 0, 5, 2);

    do_cmd(OP_CLR, 0, lat, busy);
    check("clr_lat",   lat,      8);
    check("clr_busy",  busy,     8);
    check("clr_found", io.rsp_found, 0);
    check("clr_idx",   io.rsp_idx,   7);
    check("clr_empty", io.empty, 1);
    check("clr_count", io.count, 0);
    check("clr_led",   io.led,   0);
    cmd_rsp("find8_empty", OP_FIND, 8, 1, 0, 0, 7, 0);

    // Fresh tree 3 / - 5: confirms CLEAR wiped the old links
    cmd_rsp("re3", OP_INS, 3, 2, 0, 0, 0, 0);
    cmd_rsp("re5", OP_INS, 5, 3, 0, 0, 1, 1);

    // cmd_valid held through a walk: second command waits for IDLE
    @(negedge clk);
    io.cmd_valid = 1'b1;
    io.cmd_op    = OP_FIND;
    io.cmd_key   = 4'd5;
    @(posedge clk); #1;
    io.cmd_key = 4'd3;
    wait_rsp(lat, busy);
    check("hold_lat",   lat,          3);
    check("hold_busy",  busy,         3);
    check("hold_idx",   io.rsp_idx,   1);
    check("hold_found", io.rsp_found, 1);
    @(posedge clk); #1;
    io.cmd_valid = 1'b0;
    wait_rsp(lat, busy);
    check("held_lat", lat,        2);
    check("held_idx", io.rsp_idx, 0);

    // Reset in the middle of a walk
    @(negedge clk);
    io.cmd_valid = 1'b1;
    io.cmd_op    = OP_FIND;
    io.cmd_key   = 4'd5;
    @(posedge clk); #1;
    io.cmd_valid = 1'b0;
    check("walk_ready", io.cmd_ready, 0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ready", io.cmd_ready, 1);
    check("mid_rst_count", io.count,     0);
    check("mid_rst_valid", io.rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (io.rsp_valid) pulses++;
    end
    check("mid_rst_no_rsp", pulses,   0);
    check("mid_rst_empty",  io.empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bst_op_sched.md
Name: bst_op_sched

Overview:
- Sequencing controller for the 7-node binary-search-tree key store on the board.
- Owns the node table: a key array plus left/right child-index arrays, with index value 7 meaning null.
- Accepts FIND / INSERT / CLEAR commands over a valid/ready handshake and walks the tree one node per clock.
- Returns one response per command and drives the LED status byte. It replaces ad-hoc button-driven tree access with a single serialized command path.

Parameters:
- KEY_W, 4, key width in bits
- N_NODES, 7, node table depth; must be < 2**IDX_W
- IDX_W, 3, node index width; NULL index = N_NODES

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command (high only in IDLE)
- cmd_op  in  2  00 FIND, 01 INSERT, 10 CLEAR, 11 reserved (treated as FIND)
- cmd_key  in  KEY_W  search/insert key
- rsp_valid  out  1  one-cycle response strobe
- rsp_found  out  1  key present (FIND hit or INSERT duplicate)
- rsp_err  out  1  INSERT on full table with absent key, or walk-depth guard tripped
- rsp_idx  out  IDX_W  node index of hit or new node; NULL otherwise
- rsp_depth  out  IDX_W  depth of hit/new node, root = 0
- count  out  IDX_W  nodes in use
- empty  out  1  count == 0
- full  out  1  count == N_NODES
- led  out  8  [7] last rsp_found, [6:4] count, [3:0] last response key

Behaviour:
- Reset (async): state IDLE; count = 0; all keys = 0; all child pointers = NULL; rsp_* = 0 with rsp_idx = NULL; led = 0; cmd_ready = 1.
- Reset mid-operation aborts the command with no response.
- States: IDLE, WALK, LINK, CLR, RESP.
- Handshake: a command is accepted on a clk edge where cmd_valid && cmd_ready.
  - op and key are latched at acceptance.
  - cmd_ready = 0 in every non-IDLE state.
- IDLE, on accept:
  - FIND and empty -> RESP, found = 0.
  - INSERT and empty -> LINK, no parent.
  - CLEAR -> CLR with ptr = 0, count <= 0.
  - Otherwise -> WALK with cur = 0 (root is always node 0), depth = 0.
- WALK: one node compared per cycle.
  - key == key[cur] -> RESP, found = 1, idx = cur, no table write (INSERT duplicate included).
  - key < key[cur] -> if left[cur] != NULL then cur <= left[cur], depth++.
  - key > key[cur] -> same rule using right[cur].
  - Child is NULL, FIND -> RESP, found = 0, idx = NULL.
  - Child is NULL, INSERT and full -> RESP, err = 1.
  - Child is NULL, INSERT and not full -> LINK, remembering parent = cur, side, depth+1.
  - Guard: if depth would reach N_NODES -> RESP, err = 1. This catches table corruption.
- LINK (1 cycle):
  - key[count] <= key; left/right[count] <= NULL.
  - parent's side pointer <= count (skipped for first node).
  - rsp_idx = old count; count <= count + 1 -> RESP.
- CLR: one node per cycle sets key = 0, left/right = NULL; after ptr = N_NODES-1 -> RESP, found = 0, idx = NULL.
- RESP: rsp_valid = 1 for exactly one cycle; led updated the same edge rsp_valid rises -> IDLE.
- rsp_* fields are held stable until the next response; only rsp_valid pulses.
- Latency, edges after acceptance until rsp_valid is high:
  - FIND hit/miss ending at depth d: d+2.
  - FIND on empty: 1.
  - INSERT as child at depth d: d+2 (includes LINK).
  - INSERT on empty: 2.
  - CLEAR: N_NODES+1.
- Next command can be accepted the cycle after rsp_valid.
- count/empty/full are registered; they change only in LINK or at CLR entry.
- All key comparisons are unsigned KEY_W-bit.

Test Plan:
- INSERT 8,4,12,2 back-to-back -> rsp_idx 0,1,2,3; rsp_depth 0,1,1,2; count 4; led[6:4] = 4; each insert has rsp_err = 0.
- After the above, FIND 2 -> rsp_found = 1, idx 3, depth 2, rsp_valid exactly 4 edges after accept; FIND 5 -> found = 0, idx 7.
- INSERT 4 (duplicate) -> found = 1, idx 1, count stays 4, table unchanged (FIND 4 still idx 1).
- Insert 6,10,14 to fill (count 7, full = 1); INSERT 15 -> err = 1, count 7; INSERT 14 -> found = 1, err = 0.
- CLEAR -> cmd_ready low 8 cycles, rsp_valid on edge 8; empty = 1, led[6:4] = 0; FIND 8 -> found = 0 after 1 edge.
- cmd_valid held during WALK -> not accepted until IDLE; assert rst mid-WALK -> no rsp_valid, count = 0, cmd_ready = 1 immediately.
